// File: rtl/sonar_ranger_if.sv
// Signal bundle between a sonar ranging controller and its client logic.
// start is a one-cycle request honoured only while busy is low (no queuing);
// dist_valid is a one-cycle strobe with no backpressure, timeout qualifies it.
interface sonar_ranger_if;
  logic        start;
  logic        echo;
  logic        trig;
  logic        busy;
  logic [15:0] dist_us;
  logic        dist_valid;
  logic        timeout;

  modport master (
    output start, echo,
    input  trig, busy, dist_us, dist_valid, timeout
  );

  modport slave (
    input  start, echo,
    output trig, busy, dist_us, dist_valid, timeout
  );
endinterface

// File: rtl/sonar_ranger.sv
// Ultrasonic ranger controller: fires a trigger pulse, times the echo width
// in microseconds and reports it, with timeouts and a dead time between shots.
module sonar_ranger #(
  parameter int CLK_PER_US = 50,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int HOLDOFF_US = 20000
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  sonar_ranger_if.slave    bus,
  output logic [2:0]       state_dbg
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_MAX    = PW'(CLK_PER_US - 1);
  // Counters are compared one tick early so a transition lands exactly on
  // the edge where the count would reach its limit.
  localparam logic [15:0]   TRIG_LAST    = 16'(TRIG_US - 1);
  localparam logic [15:0]   TIMEOUT_LAST = 16'(TIMEOUT_US - 1);
  localparam logic [15:0]   HOLDOFF_LAST = 16'(HOLDOFF_US - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [15:0]   us_cnt;
  logic          echo_m;
  logic          echo_s;
  logic          echo_p;
  logic          trig_q;
  logic          busy_q;
  logic [15:0]   dist_q;
  logic          dist_valid_q;
  logic          timeout_q;

  logic us_tick;
  logic echo_rise;
  logic echo_fall;

  assign us_tick   = (presc == PRESC_MAX);
  assign echo_rise = echo_s & ~echo_p;
  assign echo_fall = ~echo_s & echo_p;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      presc        <= '0;
      us_cnt       <= '0;
      echo_m       <= 1'b0;
      echo_s       <= 1'b0;
      echo_p       <= 1'b0;
      trig_q       <= 1'b0;
      busy_q       <= 1'b0;
      dist_q       <= '0;
      dist_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      echo_m       <= bus.echo;
      echo_s       <= echo_m;
      echo_p       <= echo_s;
      dist_valid_q <= 1'b0;

      if (us_tick) begin
        presc  <= '0;
        us_cnt <= us_cnt + 16'd1;
      end else begin
        presc  <= presc + PW'(1);
      end

      // Every branch that changes state also restarts the time base.
      case (state)
        S_IDLE: begin
          presc  <= '0;
          us_cnt <= '0;
          if (bus.start) begin
            state  <= S_TRIG;
            trig_q <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        S_TRIG: begin
          if (us_tick && us_cnt == TRIG_LAST) begin
            state  <= S_WAIT_RISE;
            trig_q <= 1'b0;
            presc  <= '0;
            us_cnt <= '0;
          end
        end
        S_WAIT_RISE: begin
          if (echo_rise) begin
            state  <= S_MEASURE;
            presc  <= '0;
            us_cnt <= '0;
          end else if (us_tick && us_cnt == TIMEOUT_LAST) begin
            state        <= S_HOLDOFF;
            dist_q       <= 16'hFFFF;
            dist_valid_q <= 1'b1;
            timeout_q    <= 1'b1;
            presc        <= '0;
            us_cnt       <= '0;
          end
        end
        S_MEASURE: begin
          // A fall in the same cycle as the limit still reports a width.
          if (echo_fall) begin
            state        <= S_HOLDOFF;
            dist_q       <= us_cnt;
            dist_valid_q <= 1'b1;
            timeout_q    <= 1'b0;
            presc        <= '0;
            us_cnt       <= '0;
          end else if (us_tick && us_cnt == TIMEOUT_LAST) begin
            state        <= S_HOLDOFF;
            dist_q       <= 16'hFFFF;
            dist_valid_q <= 1'b1;
            timeout_q    <= 1'b1;
            presc        <= '0;
            us_cnt       <= '0;
          end
        end
        S_HOLDOFF: begin
          if (us_tick && us_cnt == HOLDOFF_LAST) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            presc  <= '0;
            us_cnt <= '0;
          end
        end
        default: begin
          state  <= S_IDLE;
          trig_q <= 1'b0;
          busy_q <= 1'b0;
          presc  <= '0;
          us_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.trig       = trig_q;
  assign bus.busy       = busy_q;
  assign bus.dist_us    = dist_q;
  assign bus.dist_valid = dist_valid_q;
  assign bus.timeout    = timeout_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_sonar_ranger.sv
// Randomized bench for sonar_ranger: expected results come from echo widths
// through a cycle-count model and are checked by an independent monitor.
module tb_sonar_ranger;

  localparam int CLK_PER_US = 50;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 100;
  localparam int HOLDOFF_US = 20;
  localparam int W          = 17;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [2:0] state_dbg;

  sonar_ranger_if bus ();

  sonar_ranger #(
    .CLK_PER_US (CLK_PER_US),
    .TRIG_US    (TRIG_US),
    .TIMEOUT_US (TIMEOUT_US),
    .HOLDOFF_US (HOLDOFF_US)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input bit ok, input int got, input int exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  // Reference: echo width in cycles -> {timeout, dist_us}
  function automatic logic [W-1:0] ref_result(input int width_cyc);
    if (width_cyc >= TIMEOUT_US * CLK_PER_US) return {1'b1, 16'hFFFF};
    return {1'b0, 16'(width_cyc / CLK_PER_US)};
  endfunction

  always @(negedge sys_clk) begin
    if (rst_n && bus.dist_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 1'b0, int'(bus.dist_us), 0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("timeout_flag", bus.timeout == e[16], int'(bus.timeout), int'(e[16]));
        if (e[16]) begin
          chk("dist_timeout", bus.dist_us == 16'hFFFF, int'(bus.dist_us), 16'hFFFF);
        end else begin
          chk("dist_width", (int'(bus.dist_us) >= int'(e[15:0]) - 1) && (int'(bus.dist_us) <= int'(e[15:0]) + 1),
              int'(bus.dist_us), int'(e[15:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_trig"},    bus.trig == 1'b0,       int'(bus.trig), 0);
    chk({tag, "_busy"},    bus.busy == 1'b0,       int'(bus.busy), 0);
    chk({tag, "_dist"},    bus.dist_us == 16'd0,   int'(bus.dist_us), 0);
    chk({tag, "_valid"},   bus.dist_valid == 1'b0, int'(bus.dist_valid), 0);
    chk({tag, "_timeout"}, bus.timeout == 1'b0,    int'(bus.timeout), 0);
  endtask

  task automatic wait_idle(input string tag);
    int cnt = 0;
    bit trig_bad = 0;
    while (bus.busy && cnt < 12000) begin
      if (bus.trig) trig_bad = 1;
      cnt++;
      @(negedge sys_clk);
    end
    chk({tag, "_idle_reached"}, bus.busy == 1'b0, int'(bus.busy), 0);
    chk({tag, "_no_trig_late"}, trig_bad == 1'b0, int'(trig_bad), 0);
  endtask

  task automatic fire(input bit stray, input bit pre_high, output int width);
    int cnt = 0;
    @(negedge sys_clk);
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    chk("trig_rise", bus.trig == 1'b1, int'(bus.trig), 1);
    chk("busy_rise", bus.busy == 1'b1, int'(bus.busy), 1);
    while (bus.trig && cnt < 1000) begin
      cnt++;
      bus.start = stray && (cnt == 200);
      if (pre_high && cnt == 100) bus.echo = 1'b1;
      @(negedge sys_clk);
    end
    bus.start = 1'b0;
    width = cnt;
    chk("trig_width", cnt == TRIG_US * CLK_PER_US, cnt, TRIG_US * CLK_PER_US);
  endtask

  // kind 0: echo pulse, 1: no echo, 2: echo already high before trig falls
  task automatic run_meas(input int kind, input int delay, input int width, input bit stray);
    int tw;
    int cnt;
    fire(stray, kind == 2, tw);
    if (kind == 0) exp_q.push_back(ref_result(width));
    else           exp_q.push_back({1'b1, 16'hFFFF});
    case (kind)
      0: begin
        repeat (delay) @(negedge sys_clk);
        #($urandom_range(0, 4));
        bus.echo = 1'b1;
        repeat (width / 2) @(negedge sys_clk);
        bus.start = stray;
        @(negedge sys_clk);
        bus.start = 1'b0;
        repeat (width - width / 2 - 1) @(negedge sys_clk);
        bus.echo = 1'b0;
      end
      1: begin
        cnt = 0;
        while (!bus.dist_valid && cnt < 7000) begin
          cnt++;
          @(negedge sys_clk);
        end
        chk("wait_rise_timeout_lat", cnt >= 4995 && cnt <= 5005, cnt, 5000);
        cnt = 0;
        while (bus.busy && cnt < 2000) begin
          cnt++;
          bus.start = stray && (cnt == 500);
          @(negedge sys_clk);
        end
        bus.start = 1'b0;
        chk("holdoff_len", cnt >= 995 && cnt <= 1005, cnt, 1000);
      end
      default: begin
        repeat (delay) @(negedge sys_clk);
        bus.echo = 1'b0;
      end
    endcase
    if (kind == 0 && stray) begin
      repeat (10) @(negedge sys_clk);
      bus.start = bus.busy;
      @(negedge sys_clk);
      bus.start = 1'b0;
    end
    wait_idle("meas");
    repeat (3) @(negedge sys_clk);
    chk("no_queued_start", bus.busy == 1'b0, int'(bus.busy), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.start = 1'b0;
    bus.echo  = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Directed cases
    run_meas(0, 300, 2500, 1'b1);
    run_meas(1, 0, 0, 1'b1);
    run_meas(0, 200, 8000, 1'b0);
    run_meas(2, 2000, 0, 1'b0);

    // Randomized echo widths, away from the timeout boundary
    for (int i = 0; i < 4; i++) begin
      int w;
      if ($urandom_range(0, 3) == 0) w = $urandom_range(5600, 6500);
      else                           w = $urandom_range(60, 4500);
      run_meas(0, $urandom_range(0, 2000), w, 1'(($urandom_range(0, 1))));
    end

    // Asynchronous reset in the middle of MEASURE
    begin
      int tw;
      fire(1'b0, 1'b0, tw);
      repeat (200) @(negedge sys_clk);
      bus.echo = 1'b1;
      repeat (1000) @(negedge sys_clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_measure");
      bus.echo = 1'b0;
      repeat (3) @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
    end
    run_meas(0, 500, 1700, 1'b0);

    // Asynchronous reset during TRIG must kill the pulse with no re-fire
    begin
      int seen = 0;
      @(negedge sys_clk);
      bus.start = 1'b1;
      @(negedge sys_clk);
      bus.start = 1'b0;
      repeat (100) @(negedge sys_clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_trig_drop", bus.trig == 1'b0, int'(bus.trig), 0);
      repeat (2) @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (600) begin
        @(negedge sys_clk);
        if (bus.trig || bus.busy) seen++;
      end
      chk("no_trig_after_rst", seen == 0, seen, 0);
    end
    run_meas(0, 100, 3000, 1'b0);

    repeat (10) @(negedge sys_clk);
    chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sonar_ranger.md
SONAR_RANGER -- requirements
Module: sonar_ranger

Interface
REQ-001 Parameter CLK_PER_US, default 50, sys_clk cycles per microsecond tick.
REQ-002 Parameter TRIG_US, default 10, trigger pulse width in us.
REQ-003 Parameter TIMEOUT_US, default 30000, maximum wait for echo rise and maximum echo width, in us; at most 65534.
REQ-004 Parameter HOLDOFF_US, default 20000, dead time after each measurement, in us.
REQ-005 sys_clk  input  1  single clock; all state on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  one-cycle measurement request.
REQ-008 echo  input  1  sonar echo line; asynchronous to sys_clk.
REQ-009 trig  output  1  sonar trigger; drives the xt/xr/xb/xl trig pin.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 dist_us  output  16  last echo width in whole us; 16'hFFFF on timeout.
REQ-012 dist_valid  output  1  one-cycle strobe when dist_us updates.
REQ-013 timeout  output  1  high with dist_valid when the measurement timed out; holds until the next dist_valid.

Function
REQ-014 echo SHALL pass through a 2-flop synchronizer; all echo decisions use the synchronized value echo_s and its previous sample.
REQ-015 A prescaler SHALL count 0..CLK_PER_US-1 and emit us_tick on the terminal count; it SHALL clear to 0 on every state transition.
REQ-016 A 16-bit us counter SHALL clear on every state transition and increment on us_tick.
REQ-017 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
REQ-018 IDLE: start=1 -> TRIG on the next edge; trig rises in that same edge.
REQ-019 start SHALL be ignored in every state except IDLE; no queuing.
REQ-020 TRIG: trig=1; at us count == TRIG_US -> WAIT_RISE with trig=0; trig width SHALL be exactly TRIG_US*CLK_PER_US cycles.
REQ-021 WAIT_RISE: echo_s rising edge -> MEASURE; us count reaching TIMEOUT_US first -> timeout result, then HOLDOFF.
REQ-022 An echo already high on entry to WAIT_RISE SHALL NOT count as a rise; only a 0->1 transition of echo_s does.
REQ-023 MEASURE: echo_s falling edge -> dist_us = us count (completed ticks), dist_valid=1, timeout=0, then HOLDOFF.
REQ-024 MEASURE: us count reaching TIMEOUT_US with echo_s still high -> timeout result, then HOLDOFF.
REQ-025 Timeout result: dist_us=16'hFFFF, dist_valid=1, timeout=1, all in one cycle.
REQ-026 If a falling edge and the timeout condition occur in the same cycle, the falling edge wins.
REQ-027 Reported width SHALL equal floor(echo high cycles / CLK_PER_US) with a tolerance of +/-1 us.
REQ-028 HOLDOFF: at us count == HOLDOFF_US -> IDLE; echo activity is ignored.
REQ-029 dist_us SHALL hold its value between dist_valid strobes.
REQ-030 trig SHALL be a registered output, glitch-free, and high only in TRIG.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, trig=0, busy=0, dist_us=0, dist_valid=0, timeout=0, prescaler and us counter 0, synchronizer flops 0.
REQ-032 Reset during TRIG SHALL drop trig asynchronously, with no extra pulse after release.
REQ-033 After rst_n deasserts, the first start accepted SHALL behave exactly like a start accepted from IDLE.

Verification (CLK_PER_US=50, TRIG_US=10, TIMEOUT_US=100, HOLDOFF_US=20)
REQ-034 start pulse -> trig high exactly 500 cycles starting 1 cycle later; busy high from the same edge.
REQ-035 echo high for 2500 cycles, 300 cycles after trig falls -> single dist_valid, dist_us in 49..51, timeout=0.
REQ-036 echo never rises -> dist_valid, dist_us=16'hFFFF, timeout=1 about 5000 cycles after trig falls; busy low 1000 cycles later.
REQ-037 echo held high 8000 cycles -> timeout result; the later fall is ignored (no second strobe).
REQ-038 start repeated in TRIG/MEASURE/HOLDOFF -> ignored; a start in IDLE after HOLDOFF -> new trig.
REQ-039 rst_n low mid-MEASURE -> all outputs reach reset values without waiting for a sys_clk edge; after release, a new measurement gives a correct result.
